// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one single-port synchronous SRAM (active-low CEN/WEN) between the
// serial control loader (CTRL) and the serial CPU. Each access walks a fixed
// IDLE -> ISSUE -> WAIT -> RESP sequence, so throughput is one access per
// four cycles. The CPU has priority, but after MAX_WAIT consecutive CPU grants
// with CTRL pending, CTRL is forced through. CTRL_LOCK shuts the CPU out.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   CTRL_LOCK                serve only CTRL while high (sampled in IDLE)
//   CTRL_REQ/WE/ADDR/WDATA   CTRL request; fields sampled at the grant edge
//   CTRL_GNT/ACK/RDATA       CTRL owns SRAM / completion pulse / read data
//   CPU_*                    same set for the CPU side
//   SRAM_CEN/WEN/A/D         registered SRAM macro controls
//   SRAM_Q                   SRAM read data, valid the cycle after sampling
//   BUSY                     sequencer not in IDLE
//
// Optional feature (macro SRAM_ARB_STATS_EN): adds saturating 16-bit grant
// counters CTRL_GNT_CNT and CPU_GNT_CNT, cleared by RST.

module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CTRL_LOCK,
    input  logic                  CTRL_REQ,
    input  logic                  CTRL_WE,
    input  logic [ADDR_WIDTH-1:0] CTRL_ADDR,
    input  logic [DATA_WIDTH-1:0] CTRL_WDATA,
    output logic                  CTRL_GNT,
    output logic                  CTRL_ACK,
    output logic [DATA_WIDTH-1:0] CTRL_RDATA,
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
    input  logic [DATA_WIDTH-1:0] CPU_WDATA,
    output logic                  CPU_GNT,
    output logic                  CPU_ACK,
    output logic [DATA_WIDTH-1:0] CPU_RDATA,
    output logic                  SRAM_CEN,
    output logic                  SRAM_WEN,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    input  logic [DATA_WIDTH-1:0] SRAM_Q,
    output logic                  BUSY
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]           CTRL_GNT_CNT,
    output logic [15:0]           CPU_GNT_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);

    state_t                state_q, state_d;
    logic [3:0]            wait_q, wait_d;
    logic                  owner_ctrl_q;   // 1 = CTRL owns the current access
    logic                  we_q;
    logic                  cen_q, wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] ctrl_rdata_q, cpu_rdata_q;
    logic                  gnt_ctrl_d, gnt_cpu_d;

    always_comb begin
        gnt_ctrl_d = 1'b0;
        gnt_cpu_d  = 1'b0;
        wait_d     = wait_q;
        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                if (CTRL_LOCK) begin
                    gnt_ctrl_d = CTRL_REQ;
                end else if (CTRL_REQ && CPU_REQ) begin
                    // Starvation guard: CTRL wins once the CPU has had its quota.
                    if (wait_q >= MAX_WAIT_L) gnt_ctrl_d = 1'b1;
                    else                      gnt_cpu_d  = 1'b1;
                end else begin
                    gnt_ctrl_d = CTRL_REQ;
                    gnt_cpu_d  = CPU_REQ;
                end
                if (!CTRL_REQ || gnt_ctrl_d) wait_d = 4'd0;
                else if (gnt_cpu_d)          wait_d = wait_q + 4'd1;
                if (gnt_ctrl_d || gnt_cpu_d) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_RESP;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            wait_q       <= 4'd0;
            owner_ctrl_q <= 1'b0;
            we_q         <= 1'b0;
            cen_q        <= 1'b1;
            wen_q        <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            ctrl_rdata_q <= '0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (gnt_ctrl_d || gnt_cpu_d) begin
                owner_ctrl_q <= gnt_ctrl_d;
                we_q         <= gnt_ctrl_d ? CTRL_WE    : CPU_WE;
                addr_q       <= gnt_ctrl_d ? CTRL_ADDR  : CPU_ADDR;
                wdata_q      <= gnt_ctrl_d ? CTRL_WDATA : CPU_WDATA;
                cen_q        <= 1'b0;
                wen_q        <= gnt_ctrl_d ? ~CTRL_WE   : ~CPU_WE;
            end
            if (state_q == ST_ISSUE) begin
                cen_q <= 1'b1;
                wen_q <= 1'b1;
            end
            // SRAM_Q is valid during WAIT for the read sampled at the end of ISSUE.
            if (state_q == ST_WAIT && !we_q) begin
                if (owner_ctrl_q) ctrl_rdata_q <= SRAM_Q;
                else              cpu_rdata_q  <= SRAM_Q;
            end
        end
    end

    assign CTRL_GNT   = (state_q != ST_IDLE) &&  owner_ctrl_q;
    assign CPU_GNT    = (state_q != ST_IDLE) && !owner_ctrl_q;
    assign CTRL_ACK   = (state_q == ST_RESP) &&  owner_ctrl_q;
    assign CPU_ACK    = (state_q == ST_RESP) && !owner_ctrl_q;
    assign CTRL_RDATA = ctrl_rdata_q;
    assign CPU_RDATA  = cpu_rdata_q;
    assign SRAM_CEN   = cen_q;
    assign SRAM_WEN   = wen_q;
    assign SRAM_A     = addr_q;
    assign SRAM_D     = wdata_q;
    assign BUSY       = (state_q != ST_IDLE);

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] ctrl_cnt_q, cpu_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_cnt_q <= '0;
            cpu_cnt_q  <= '0;
        end else begin
            if (gnt_ctrl_d && ctrl_cnt_q != 16'hFFFF) ctrl_cnt_q <= ctrl_cnt_q + 16'd1;
            if (gnt_cpu_d  && cpu_cnt_q  != 16'hFFFF) cpu_cnt_q  <= cpu_cnt_q + 16'd1;
        end
    end

    assign CTRL_GNT_CNT = ctrl_cnt_q;
    assign CPU_GNT_CNT  = cpu_cnt_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a cycle table for single accesses, then
// hand-written sequences for arbitration fairness, CTRL_LOCK, mid-access
// reset and (when SRAM_ARB_STATS_EN is defined) the grant counters.

module tb_sram_port_arbiter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       CTRL_LOCK, CTRL_REQ, CTRL_WE;
    logic [8:0] CTRL_ADDR;
    logic [7:0] CTRL_WDATA;
    logic       CTRL_GNT, CTRL_ACK;
    logic [7:0] CTRL_RDATA;
    logic       CPU_REQ, CPU_WE;
    logic [8:0] CPU_ADDR;
    logic [7:0] CPU_WDATA;
    logic       CPU_GNT, CPU_ACK;
    logic [7:0] CPU_RDATA;
    logic       SRAM_CEN, SRAM_WEN;
    logic [8:0] SRAM_A;
    logic [7:0] SRAM_D;
    logic [7:0] SRAM_Q;
    logic       BUSY;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] CTRL_GNT_CNT, CPU_GNT_CNT;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    sram_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .MAX_WAIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .CTRL_LOCK(CTRL_LOCK), .CTRL_REQ(CTRL_REQ), .CTRL_WE(CTRL_WE),
        .CTRL_ADDR(CTRL_ADDR), .CTRL_WDATA(CTRL_WDATA),
        .CTRL_GNT(CTRL_GNT), .CTRL_ACK(CTRL_ACK), .CTRL_RDATA(CTRL_RDATA),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_GNT(CPU_GNT), .CPU_ACK(CPU_ACK), .CPU_RDATA(CPU_RDATA),
        .SRAM_CEN(SRAM_CEN), .SRAM_WEN(SRAM_WEN), .SRAM_A(SRAM_A), .SRAM_D(SRAM_D),
        .SRAM_Q(SRAM_Q), .BUSY(BUSY)
`ifdef SRAM_ARB_STATS_EN
        , .CTRL_GNT_CNT(CTRL_GNT_CNT), .CPU_GNT_CNT(CPU_GNT_CNT)
`endif
    );

    // Behavioural 512x8 single-port SRAM macro.
    logic [7:0] mem [0:511];
    always @(posedge CLK) begin
        if (!SRAM_CEN) begin
            if (!SRAM_WEN) mem[SRAM_A] <= SRAM_D;
            else           SRAM_Q <= mem[SRAM_A];
        end
    end

    typedef struct {
        logic       rst, lock, c_req, c_we;
        logic [8:0] c_addr;
        logic [7:0] c_wd;
        logic       p_req, p_we;
        logic [8:0] p_addr;
        logic [7:0] p_wd;
        logic       cen, wen;
        logic [8:0] a;
        logic [7:0] d;
        logic       c_gnt, c_ack, p_gnt, p_ack, busy;
        logic [7:0] c_rd, p_rd;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(
        input logic rst, lock, c_req, c_we, input logic [8:0] c_addr, input logic [7:0] c_wd,
        input logic p_req, p_we, input logic [8:0] p_addr, input logic [7:0] p_wd,
        input logic cen, wen, input logic [8:0] a, input logic [7:0] d,
        input logic c_gnt, c_ack, p_gnt, p_ack, busy, input logic [7:0] c_rd, p_rd);
        vec_t v;
        v.rst = rst; v.lock = lock; v.c_req = c_req; v.c_we = c_we;
        v.c_addr = c_addr; v.c_wd = c_wd; v.p_req = p_req; v.p_we = p_we;
        v.p_addr = p_addr; v.p_wd = p_wd; v.cen = cen; v.wen = wen; v.a = a; v.d = d;
        v.c_gnt = c_gnt; v.c_ack = c_ack; v.p_gnt = p_gnt; v.p_ack = p_ack;
        v.busy = busy; v.c_rd = c_rd; v.p_rd = p_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        RST = 1'b0; CTRL_LOCK = 1'b0;
        CTRL_REQ = 1'b0; CTRL_WE = 1'b0; CTRL_ADDR = '0; CTRL_WDATA = '0;
        CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_WDATA = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 10) begin
            step();
            n++;
        end
        chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    // One complete access from IDLE; side 1 = CTRL, 0 = CPU.
    task automatic access(input logic side, input logic we, input logic [8:0] addr,
                          input logic [7:0] wd);
        if (side) begin
            CTRL_REQ = 1'b1; CTRL_WE = we; CTRL_ADDR = addr; CTRL_WDATA = wd;
        end else begin
            CPU_REQ = 1'b1; CPU_WE = we; CPU_ADDR = addr; CPU_WDATA = wd;
        end
        step();
        CTRL_REQ = 1'b0; CPU_REQ = 1'b0;
        step(); step(); step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cen"},   {31'd0, SRAM_CEN}, 32'd1);
        chk({tag, "_wen"},   {31'd0, SRAM_WEN}, 32'd1);
        chk({tag, "_a"},     {23'd0, SRAM_A},   32'd0);
        chk({tag, "_d"},     {24'd0, SRAM_D},   32'd0);
        chk({tag, "_gntack"}, {28'd0, CTRL_GNT, CTRL_ACK, CPU_GNT, CPU_ACK}, 32'd0);
        chk({tag, "_busy"},  {31'd0, BUSY},     32'd0);
        chk({tag, "_crd"},   {24'd0, CTRL_RDATA}, 32'd0);
        chk({tag, "_prd"},   {24'd0, CPU_RDATA},  32'd0);
    endtask

    initial begin
        idle_inputs();
        RST = 1'b1;

        //            rst lk cr cw caddr   cwd    pr pw paddr   pwd  | cen wen a      d      cg ca pg pa bsy crd    prd
        tbl[0]  = mk(1, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h000, 8'h00, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        tbl[1]  = mk(0, 1, 1, 1, 9'h020, 8'h3C, 0, 0, 9'h000, 8'h00, 0, 0, 9'h020, 8'h3C, 1, 0, 0, 0, 1, 8'h00, 8'h00);
        tbl[2]  = mk(0, 1, 0, 1, 9'h1FF, 8'hFF, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h3C, 1, 0, 0, 0, 1, 8'h00, 8'h00);
        tbl[3]  = mk(0, 1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h3C, 1, 1, 0, 0, 1, 8'h00, 8'h00);
        tbl[4]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'h3C, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        tbl[5]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 1, 0, 9'h020, 8'hA5, 0, 1, 9'h020, 8'hA5, 0, 0, 1, 0, 1, 8'h00, 8'h00);
        tbl[6]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'hA5, 0, 0, 1, 0, 1, 8'h00, 8'h00);
        tbl[7]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'hA5, 0, 0, 1, 1, 1, 8'h00, 8'h3C);
        tbl[8]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h020, 8'hA5, 0, 0, 0, 0, 0, 8'h00, 8'h3C);
        tbl[9]  = mk(0, 0, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h81, 0, 0, 9'h1FF, 8'h81, 0, 0, 1, 0, 1, 8'h00, 8'h3C);
        tbl[10] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h81, 0, 0, 1, 0, 1, 8'h00, 8'h3C);
        tbl[11] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h81, 0, 0, 1, 1, 1, 8'h00, 8'h3C);
        tbl[12] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h81, 0, 0, 0, 0, 0, 8'h00, 8'h3C);
        tbl[13] = mk(0, 0, 1, 0, 9'h1FF, 8'h00, 0, 0, 9'h000, 8'h00, 0, 1, 9'h1FF, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h3C);
        tbl[14] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h00, 1, 0, 0, 0, 1, 8'h00, 8'h3C);
        tbl[15] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h00, 1, 1, 0, 0, 1, 8'h81, 8'h3C);
        tbl[16] = mk(0, 0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 1, 1, 9'h1FF, 8'h00, 0, 0, 0, 0, 0, 8'h81, 8'h3C);

        for (int i = 0; i < 17; i++) begin
            RST = tbl[i].rst; CTRL_LOCK = tbl[i].lock;
            CTRL_REQ = tbl[i].c_req; CTRL_WE = tbl[i].c_we;
            CTRL_ADDR = tbl[i].c_addr; CTRL_WDATA = tbl[i].c_wd;
            CPU_REQ = tbl[i].p_req; CPU_WE = tbl[i].p_we;
            CPU_ADDR = tbl[i].p_addr; CPU_WDATA = tbl[i].p_wd;
            step();
            chk($sformatf("v%0d_cen", i),  {31'd0, SRAM_CEN}, {31'd0, tbl[i].cen});
            chk($sformatf("v%0d_wen", i),  {31'd0, SRAM_WEN}, {31'd0, tbl[i].wen});
            chk($sformatf("v%0d_a", i),    {23'd0, SRAM_A},   {23'd0, tbl[i].a});
            chk($sformatf("v%0d_d", i),    {24'd0, SRAM_D},   {24'd0, tbl[i].d});
            chk($sformatf("v%0d_cgnt", i), {31'd0, CTRL_GNT}, {31'd0, tbl[i].c_gnt});
            chk($sformatf("v%0d_cack", i), {31'd0, CTRL_ACK}, {31'd0, tbl[i].c_ack});
            chk($sformatf("v%0d_pgnt", i), {31'd0, CPU_GNT},  {31'd0, tbl[i].p_gnt});
            chk($sformatf("v%0d_pack", i), {31'd0, CPU_ACK},  {31'd0, tbl[i].p_ack});
            chk($sformatf("v%0d_busy", i), {31'd0, BUSY},     {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_crd", i),  {24'd0, CTRL_RDATA}, {24'd0, tbl[i].c_rd});
            chk($sformatf("v%0d_prd", i),  {24'd0, CPU_RDATA},  {24'd0, tbl[i].p_rd});
        end

        // Both requesters held: CPU x4 then CTRL, repeating.
        begin
            logic exp_ctrl [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            int   got = 0;
            int   run = 0;
            logic prev_busy;
            idle_inputs();
            CTRL_REQ = 1'b1; CTRL_ADDR = 9'h010;
            CPU_REQ  = 1'b1; CPU_ADDR  = 9'h011;
            prev_busy = BUSY;
            for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
                step();
                if (BUSY && !prev_busy) begin
                    chk($sformatf("arb_grant%0d", got), {31'd0, CTRL_GNT}, {31'd0, exp_ctrl[got]});
                    run = CPU_GNT ? run + 1 : 0;
                    got++;
                end
                prev_busy = BUSY;
            end
            chk("arb_grant_count", got, 10);
            chk("arb_max_cpu_run_le4", {31'd0, run > 4}, 32'd0);
            CTRL_REQ = 1'b0; CPU_REQ = 1'b0;
            wait_idle();
            step();
        end

        // CTRL_LOCK holds the CPU off; release lets it in at the next edge.
        begin
            int bad = 0;
            CTRL_LOCK = 1'b1;
            CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 9'h020;
            for (int c = 0; c < 20; c++) begin
                step();
                if (CPU_GNT || BUSY) bad++;
            end
            chk("lock_cpu_blocked", bad, 0);
            CTRL_LOCK = 1'b0;
            step();
            chk("lock_release_gnt", {31'd0, CPU_GNT}, 32'd1);
            CPU_REQ = 1'b0;
            step();
            // Now in WAIT of a CPU read: reset here.
            RST = 1'b1;
            step();
            RST = 1'b0;
            chk_reset_outputs("rst_mid");
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                step();
                if (CPU_ACK || BUSY) bad++;
            end
            chk("rst_no_ack", bad, 0);
        end

        // Fresh CTRL write after reset, then read it back from the CPU side.
        CTRL_REQ = 1'b1; CTRL_WE = 1'b1; CTRL_ADDR = 9'h055; CTRL_WDATA = 8'h99;
        step();
        chk("post_rst_cen", {31'd0, SRAM_CEN}, 32'd0);
        chk("post_rst_wen", {31'd0, SRAM_WEN}, 32'd0);
        chk("post_rst_a",   {23'd0, SRAM_A},   32'h055);
        chk("post_rst_d",   {24'd0, SRAM_D},   32'h99);
        CTRL_REQ = 1'b0;
        step(); step();
        chk("post_rst_cack", {31'd0, CTRL_ACK}, 32'd1);
        step();
        access(1'b0, 1'b0, 9'h055, 8'h00);
        chk("post_rst_readback", {24'd0, CPU_RDATA}, 32'h99);

`ifdef SRAM_ARB_STATS_EN
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int k = 0; k < 10; k++) access(1'b0, 1'b0, 9'(k), 8'h00);
        for (int k = 0; k < 3; k++)  access(1'b1, 1'b0, 9'(k), 8'h00);
        chk("stats_cpu",  {16'd0, CPU_GNT_CNT},  32'd10);
        chk("stats_ctrl", {16'd0, CTRL_GNT_CNT}, 32'd3);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("stats_cpu_rst",  {16'd0, CPU_GNT_CNT},  32'd0);
        chk("stats_ctrl_rst", {16'd0, CTRL_GNT_CNT}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port 512x8 synchronous SRAM (active-low CEN/WEN macro) between two requesters: the serial control loader (CTRL side) and the serial CPU (CPU side).
- Serialises accesses through a fixed 4-state sequencer.
- Arbitration is CPU-priority with a CTRL starvation guard and a CTRL exclusive-lock input driven by the CTRL_BGN path.
- Sits in the top level between the control shift-register block, the CPU and the SRAM macro.

Parameters:
- ADDR_WIDTH, 9, SRAM address bits.
- DATA_WIDTH, 8, SRAM data bits.
- MAX_WAIT, 4, consecutive CPU grants allowed while CTRL is pending before CTRL is forced (range 1..15).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- CTRL_LOCK  in  1  1 = only CTRL is served; CPU requests stay pending.
- CTRL_REQ  in  1  CTRL access request, level.
- CTRL_WE  in  1  1 = write, 0 = read.
- CTRL_ADDR  in  ADDR_WIDTH  CTRL address.
- CTRL_WDATA  in  DATA_WIDTH  CTRL write data.
- CTRL_GNT  out  1  CTRL owns the SRAM.
- CTRL_ACK  out  1  one-cycle completion pulse.
- CTRL_RDATA  out  DATA_WIDTH  read data, valid while CTRL_ACK=1.
- CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, CPU_GNT, CPU_ACK, CPU_RDATA  same as CTRL_* for the CPU side.
- SRAM_CEN  out  1  chip enable, active-low, registered.
- SRAM_WEN  out  1  write enable, active-low, registered.
- SRAM_A  out  ADDR_WIDTH  address, registered.
- SRAM_D  out  DATA_WIDTH  write data, registered.
- SRAM_Q  in  DATA_WIDTH  SRAM read data, valid the cycle after the sampling edge.
- BUSY  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, RST=1 at rising edge) values:
  - State = IDLE.
  - SRAM_CEN=1, SRAM_WEN=1, SRAM_A=0, SRAM_D=0.
  - All GNT/ACK=0, both RDATA=0, BUSY=0.
  - Starvation counter = 0.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Every transition is unconditional except IDLE.
- IDLE:
  - On an edge with a winner (see arbitration), latch owner, WE, ADDR and WDATA. Go to ISSUE.
  - SRAM_CEN goes 0 and SRAM_WEN = ~WE for the ISSUE cycle only.
- ISSUE: SRAM samples at the closing edge. SRAM_CEN/SRAM_WEN return to 1 at that edge.
- WAIT: on reads, SRAM_Q is captured into the owner's RDATA at the closing edge. On writes, RDATA is unchanged.
- RESP: owner ACK=1 for exactly one cycle.
- GNT: owner GNT=1 in ISSUE, WAIT and RESP; 0 in IDLE.
- Latency: REQ sampled in IDLE at edge N gives ACK high during cycle N+3. Back-to-back throughput is one access per 4 cycles.
- Request fields are sampled only at the grant edge. Changes after that are ignored.
- REQ dropped before ACK: the access still completes and ACK still pulses. Abort is not supported.
- REQ still high in the cycle after ACK is treated as a new request.
- Arbitration (evaluated in IDLE only):
  - CTRL_LOCK=1: grant CTRL if CTRL_REQ=1, else stay IDLE. CPU_REQ is ignored and not dropped.
  - CTRL_LOCK=0 and only one REQ high: grant it.
  - Both high and wait counter < MAX_WAIT: grant CPU and increment the counter.
  - Both high and wait counter = MAX_WAIT: grant CTRL.
  - The counter clears on any CTRL grant and whenever CTRL_REQ=0 in IDLE. It never exceeds MAX_WAIT.
- CTRL_LOCK changes take effect only at the next IDLE decision. An in-flight CPU access completes normally.
- Reset mid-operation:
  - Sequencer returns to IDLE at the reset edge and no ACK is generated.
  - A write whose ISSUE cycle coincides with the reset edge is committed by the SRAM. Software must not rely on this.
- Address and data paths are pass-through at the parameter width. No wrap, truncation or arithmetic is applied.

Optional Feature:
- Macro: SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs CTRL_GNT_CNT[15:0] and CPU_GNT_CNT[15:0].
  - Each increments on its side's grant edge and saturates at 16'hFFFF.
  - Both clear on RST.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then CTRL write addr 9'h020 data 8'h3C with CTRL_LOCK=1 -> SRAM_CEN=0, WEN=0, A=9'h020, D=8'h3C for exactly one cycle; CTRL_ACK at cycle N+3.
- CPU read of addr 9'h020 after that write -> CPU_ACK pulses one cycle with CPU_RDATA=8'h3C; SRAM_WEN stays 1 throughout.
- Both REQ held high continuously, CTRL_LOCK=0, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,CTRL repeating; never 5 consecutive CPU grants.
- CTRL_LOCK=1 with only CPU_REQ high for 20 cycles -> no CPU_GNT, BUSY=0. Drop CTRL_LOCK -> CPU granted at the next edge.
- Assert RST during WAIT of a CPU read -> next cycle all outputs at reset values and no CPU_ACK. A fresh CTRL write then completes normally.
- With SRAM_ARB_STATS_EN, run 10 CPU + 3 CTRL accesses -> CPU_GNT_CNT=10, CTRL_GNT_CNT=3. Pulse RST -> both counters = 0.
